// File: rtl/reg_context_unit.sv
// Register-context sequencer: spills general registers FIRST_REG..LAST_REG to a
// contiguous memory block (save) or reloads them from it (restore).
module reg_context_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 6,
    parameter int ADDR_W    = 32,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 63
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] Base_Addr,
    output logic              Busy,
    output logic              Done,
    output logic [REG_AW-1:0] Reg_Sel,
    input  logic [DATA_W-1:0] Reg_Data,
    output logic              Reg_Write,
    output logic [DATA_W-1:0] Write_Data,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] Mem_Wdata,
    output logic              Mem_Read,
    input  logic              Mem_Ready,
    input  logic [DATA_W-1:0] Mem_Rdata,
    output logic [2:0]        Dbg_State
);

    // Handshake: a memory request (Mem_Write or Mem_Read) is held unchanged until
    // the cycle Mem_Ready is high; that edge completes it. Read data arrives the
    // following cycle. Reg_Write is a single-cycle strobe with no back-pressure.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAVE    = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_REG  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(FIRST_REG);
    localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(LAST_REG);

    state_t              r_state;
    logic [REG_AW-1:0]   r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_base;

    logic [REG_AW-1:0]   w_offset;
    logic [ADDR_W-1:0]   w_slot;
    logic                w_last;

    assign w_offset = r_idx - FIRST_IDX;
    assign w_slot   = r_base + ADDR_W'(w_offset);
    assign w_last   = (r_idx == LAST_IDX);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_idx   <= FIRST_IDX;
            r_data  <= '0;
            r_mode  <= 1'b0;
            r_base  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mode  <= Mode;
                        r_base  <= Base_Addr;
                        r_idx   <= FIRST_IDX;
                        r_state <= Mode ? S_RD_REQ : S_SAVE;
                    end
                end
                S_SAVE: begin
                    if (Mem_Ready) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (Mem_Ready) begin
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_data  <= Mem_Rdata;
                    r_state <= S_WR_REG;
                end
                S_WR_REG: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_RD_REQ;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Mem_Wdata forwards the register file's read data for Reg_Sel, which is
    // itself registered, so no input-to-output path exists outside that read.
    always_comb begin
        Busy       = 1'b0;
        Done       = 1'b0;
        Reg_Sel    = '0;
        Reg_Write  = 1'b0;
        Write_Data = '0;
        Mem_Addr   = '0;
        Mem_Write  = 1'b0;
        Mem_Wdata  = '0;
        Mem_Read   = 1'b0;
        case (r_state)
            S_SAVE: begin
                Busy      = 1'b1;
                Reg_Sel   = r_idx;
                Mem_Addr  = w_slot;
                Mem_Write = ~r_mode;
                Mem_Wdata = Reg_Data;
            end
            S_RD_REQ: begin
                Busy     = 1'b1;
                Mem_Addr = w_slot;
                Mem_Read = r_mode;
            end
            S_RD_WAIT: begin
                Busy = 1'b1;
            end
            S_WR_REG: begin
                Busy       = 1'b1;
                Reg_Sel    = r_idx;
                Reg_Write  = 1'b1;
                Write_Data = r_data;
            end
            S_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    assign Dbg_State = r_state;

endmodule

// File: tb/tb_reg_context_unit.sv
// Directed bench for reg_context_unit: save, stalled save, ignored starts,
// restore abort by reset, full restore, and a narrow range with address wrap.
module tb_reg_context_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, mem_ready;
    logic [31:0] base;
    logic        busy, done, reg_write, mem_write, mem_read;
    logic [5:0]  reg_sel;
    logic [31:0] reg_data, write_data, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  dbg_state;

    logic        start2;
    logic        busy2, done2, reg_write2, mem_write2, mem_read2;
    logic [5:0]  reg_sel2;
    logic [31:0] reg_data2, write_data2, mem_addr2, mem_wdata2;
    logic [2:0]  dbg_state2;

    reg_context_unit dut (
        .Clock(clk), .Reset(rst), .Start(start), .Mode(mode), .Base_Addr(base),
        .Busy(busy), .Done(done), .Reg_Sel(reg_sel), .Reg_Data(reg_data),
        .Reg_Write(reg_write), .Write_Data(write_data), .Mem_Addr(mem_addr),
        .Mem_Write(mem_write), .Mem_Wdata(mem_wdata), .Mem_Read(mem_read),
        .Mem_Ready(mem_ready), .Mem_Rdata(mem_rdata), .Dbg_State(dbg_state)
    );

    reg_context_unit #(.FIRST_REG(51), .LAST_REG(56)) dut2 (
        .Clock(clk), .Reset(rst), .Start(start2), .Mode(1'b0), .Base_Addr(32'hFFFF_FFFE),
        .Busy(busy2), .Done(done2), .Reg_Sel(reg_sel2), .Reg_Data(reg_data2),
        .Reg_Write(reg_write2), .Write_Data(write_data2), .Mem_Addr(mem_addr2),
        .Mem_Write(mem_write2), .Mem_Wdata(mem_wdata2), .Mem_Read(mem_read2),
        .Mem_Ready(1'b1), .Mem_Rdata(32'd0), .Dbg_State(dbg_state2)
    );

    // Register file and memory models; the memory returns 0x5500 + (addr - 0x200).
    logic [31:0] regs [64];
    logic        load_en = 1'b0, clr_en = 1'b0;
    logic [31:0] wr_addr_q[$], wr_data_q[$], addr2_q[$], data2_q[$];
    int          rw_cnt, rd_cnt, both_cnt, done_cnt;

    assign reg_data  = regs[reg_sel];
    assign reg_data2 = 32'hB000 + {26'd0, reg_sel2};

    always @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < 64; k++) regs[k] <= 32'hA000 + 32'(k);
        end else if (reg_write) begin
            regs[reg_sel] <= write_data;
        end
        mem_rdata <= (mem_read && mem_ready) ? (mem_addr - 32'h200 + 32'h5500) : 32'hBAD0_BAD0;
        if (clr_en) begin
            wr_addr_q.delete(); wr_data_q.delete(); addr2_q.delete(); data2_q.delete();
            rw_cnt <= 0; rd_cnt <= 0; both_cnt <= 0; done_cnt <= 0;
        end else begin
            if (mem_write && mem_ready) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (mem_write2) begin
                addr2_q.push_back(mem_addr2);
                data2_q.push_back(mem_wdata2);
            end
            if (reg_write) rw_cnt <= rw_cnt + 1;
            if (mem_read && mem_ready) rd_cnt <= rd_cnt + 1;
            if (mem_read && mem_write) both_cnt <= both_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 ns after a posedge; returns 1 ns after a posedge.
    task automatic prep(input logic ld);
        clr_en = 1'b1; load_en = ld;
        @(posedge clk); #1;
        clr_en = 1'b0; load_en = 1'b0;
    endtask

    // Cycle c is the c-th cycle after the edge that accepts Start.
    task automatic run_xfer(input logic m, input logic [31:0] b, input int toggle,
                            input int reset_at, input int ign_a, input int ign_b,
                            input int bound, output int done_cyc);
        bit hit;
        hit = 1'b0;
        done_cyc = 0;
        start = 1'b1; mode = m; base = b; mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; base = b ^ 32'h0000_0F00;
        for (int c = 1; c <= bound; c++) begin
            mem_ready = (toggle == 0) || ((c - 1) % 3 == 0);
            start = (c == ign_a) || (c == ign_b);
            if (c == reset_at) rst = 1'b1;
            @(negedge clk);
            if (toggle != 0 && mem_write && !mem_ready) begin
                check("stall_addr", mem_addr, b + 32'(wr_addr_q.size()));
                check("stall_wdata", mem_wdata, 32'hA001 + 32'(wr_addr_q.size()));
            end
            if (done) begin
                done_cyc = c;
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
            rst = 1'b0;
        end
        if (hit) begin
            @(posedge clk); #1;
        end
        start = 1'b0; mem_ready = 1'b1; rst = 1'b0;
    endtask

    task automatic check_save_seq(input string tag, input logic [31:0] b);
        check({tag, "_count"}, 32'(wr_addr_q.size()), 32'd63);
        for (int i = 0; i < 63 && i < wr_addr_q.size(); i++) begin
            check({tag, "_addr"}, wr_addr_q[i], b + 32'(i));
            check({tag, "_data"}, wr_data_q[i], 32'hA001 + 32'(i));
        end
    endtask

    int dc, idle_bad;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; base = '0; mem_ready = 1'b1; start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_reg_sel", {26'd0, reg_sel}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Save with Start pulses (other mode/base) at cycle 10 and in DONE.
        prep(1'b1);
        run_xfer(1'b0, 32'h100, 0, 0, 10, 64, 200, dc);
        check("save_done_cycle", 32'(dc), 32'd64);
        check_save_seq("save", 32'h100);
        check("save_reg_writes", 32'(rw_cnt), 32'd0);
        check("save_mem_reads", 32'(rd_cnt), 32'd0);
        idle_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) idle_bad++;
        end
        @(posedge clk); #1;
        check("ignored_start_idle", 32'(idle_bad), 32'd0);
        check("save_done_count", 32'(done_cnt), 32'd1);

        // Save with Mem_Ready = 1,0,0,...: 124 stall cycles.
        prep(1'b0);
        run_xfer(1'b0, 32'h100, 1, 0, 0, 0, 400, dc);
        check("stall_done_cycle", 32'(dc), 32'd188);
        check_save_seq("stall", 32'h100);

        // Restore aborted by reset after 10 register writes.
        prep(1'b1);
        run_xfer(1'b1, 32'h200, 0, 31, 0, 0, 31, dc);
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check("abort_mem_write", {31'd0, mem_write}, 32'd0);
        check("abort_reg_write", {31'd0, reg_write}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("abort_reg_writes", 32'(rw_cnt), 32'd10);
        for (int k = 1; k < 64; k++)
            check("abort_reg", regs[k], (k <= 10) ? 32'h5500 + 32'(k - 1) : 32'hA000 + 32'(k));

        // Full restore after the abort.
        prep(1'b1);
        run_xfer(1'b1, 32'h200, 0, 0, 0, 0, 400, dc);
        check("rest_done_cycle", 32'(dc), 32'd190);
        check("rest_reg_writes", 32'(rw_cnt), 32'd63);
        check("rest_mem_reads", 32'(rd_cnt), 32'd63);
        check("rest_both_req", 32'(both_cnt), 32'd0);
        check("rest_mem_writes", 32'(wr_addr_q.size()), 32'd0);
        check("rest_reg0", regs[0], 32'hA000);
        for (int k = 1; k < 64; k++)
            check("rest_reg", regs[k], 32'h5500 + 32'(k - 1));

        // Narrow range 51..56 with address wrap.
        prep(1'b0);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        dc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done2) begin
                dc = c;
                break;
            end
        end
        @(posedge clk); #1;
        check("wrap_done_cycle", 32'(dc), 32'd7);
        check("wrap_count", 32'(addr2_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < addr2_q.size(); i++) begin
            check("wrap_addr", addr2_q[i], 32'hFFFF_FFFE + 32'(i));
            check("wrap_data", data2_q[i], 32'hB000 + 32'(51 + i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
